inst_loader: RTL and testbench

Boot-time program loader driving the write/read port of the instruction RAM. It accepts a little-endian byte stream over a valid/ready handshake and writes each byte straight into the RAM through the per-byte write enables. It then reads the image back and checks it against a trailing 32-bit checksum. While busy it holds the CPU in reset, and it reports done or error.

---
 rtl/inst_loader.sv | 168 ++++++++++++++++
 tb/tb_inst_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction RAM loader: streams bytes into RAM, reads the image back,
// checks it against a trailing 32-bit checksum, and holds the CPU in reset while busy.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | writing image bytes into RAM, one byte lane per accepted byte
// CSUM   | collecting the 4-byte little-endian checksum trailer
// VERIFY | reading the image back and accumulating the readback sum
// DONE   | image verified, done held until next start
// ERR    | bad length or checksum mismatch, err held until next start
module inst_loader #(
    parameter int DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  len,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_adr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic        busy,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] CSUM   = 3'd2;
    localparam logic [2:0] VERIFY = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;

    logic [2:0]    state;
    logic [9:0]    len_q;
    logic [9:0]    w;
    logic [9:0]    v_cnt;
    logic [1:0]    j;
    logic [31:0]   csum;
    logic [31:0]   rsum;
    logic [31:0]   rd_q;
    logic [AW-1:0] adr_q;
    logic [3:0]    we_q;
    logic [31:0]   din_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic        xfer;
    logic        len_bad;
    logic [31:0] sum_next;

    assign xfer     = byte_valid && ready_q;
    assign len_bad  = (len == 10'd0) || ({1'b0, len} > 11'(DEPTH));
    assign sum_next = rsum + rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_q   <= '0;
            w       <= '0;
            v_cnt   <= '0;
            j       <= '0;
            csum    <= '0;
            rsum    <= '0;
            rd_q    <= '0;
            adr_q   <= '0;
            we_q    <= '0;
            din_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 4'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        done_q <= 1'b0;
                        if (len_bad) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            err_q   <= 1'b0;
                            len_q   <= len;
                            w       <= '0;
                            j       <= '0;
                            v_cnt   <= '0;
                            csum    <= '0;
                            rsum    <= '0;
                            rd_q    <= '0;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        we_q  <= 4'b0001 << j;
                        adr_q <= w[AW-1:0];
                        din_q <= {4{byte_in}};
                        j     <= j + 2'd1;
                        if (j == 2'd3) begin
                            w <= w + 10'd1;
                            if (w == len_q - 10'd1) begin
                                state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        csum[8*j +: 8] <= byte_in;
                        j              <= j + 2'd1;
                        if (j == 2'd3) begin
                            state   <= VERIFY;
                            ready_q <= 1'b0;
                            adr_q   <= '0;
                            v_cnt   <= '0;
                        end
                    end
                end
                VERIFY: begin
                    // v_cnt = k: sample word k (address driven last cycle), add word k-1.
                    v_cnt <= v_cnt + 10'd1;
                    if (v_cnt < len_q) begin
                        rd_q <= ram_dout;
                    end
                    if ((v_cnt + 10'd1) < len_q) begin
                        adr_q <= AW'(v_cnt + 10'd1);
                    end
                    if (v_cnt != 10'd0) begin
                        rsum <= sum_next;
                    end
                    if (v_cnt == len_q) begin
                        busy_q <= 1'b0;
                        if (sum_next == csum) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_ready = ready_q;
    assign ram_we     = we_q;
    assign ram_adr    = {{(32-AW){1'b0}}, adr_q};
    assign ram_din    = din_q;
    assign busy       = busy_q;
    assign cpu_rst_n  = ~busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: RAM model on negedge, image/checksum reference
// computed from the byte stream, write log compared against the expected byte sequence.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [3:0]  ram_we;
    logic [31:0] ram_adr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        busy;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    inst_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .ram_we     (ram_we),
        .ram_adr    (ram_adr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .busy       (busy),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic [3:0]  we;
        logic [31:0] adr;
        logic [31:0] din;
    } wr_t;

    logic [31:0] mem [0:511];
    wr_t         got_q[$];
    bit          busy_seen;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (ram_we[l]) mem[ram_adr[8:0]][8*l +: 8] <= ram_din[8*l +: 8];
        end
        ram_dout <= mem[ram_adr[8:0]];
        if (ram_we != 4'b0) got_q.push_back('{ram_we, ram_adr, ram_din});
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = l[9:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives bytes at negedges; a transfer is counted when valid and ready were both high.
    task automatic send(input logic [7:0] b[$], input int gap_pct);
        int  i = 0;
        int  guard = 0;
        bit  pending = 1'b0;
        while (i < b.size() && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (pending) i++;
            pending = 1'b0;
            if (i < b.size()) begin
                byte_valid = ($urandom_range(99, 0) >= gap_pct);
                byte_in    = b[i];
                pending    = byte_valid && byte_ready;
            end else begin
                byte_valid = 1'b0;
            end
        end
        byte_valid = 1'b0;
        if (guard >= 5000) check("send_timeout", 32'd1, 32'd0);
    endtask

    // Full load of l words from stream b (image then 4 trailer bytes).
    // intr_at >= 0 injects a start pulse (len=7) after that many bytes.
    task automatic do_load(input int l, input logic [7:0] b[$], input int gap_pct, input int intr_at);
        logic [31:0] words[$];
        logic [31:0] sum = 0;
        logic [31:0] trl;
        logic [7:0]  part1[$];
        logic [7:0]  part2[$];
        int          n;
        for (int k = 0; k < l; k++) begin
            words.push_back(b[4*k] + (b[4*k+1] * 32'h100) + (b[4*k+2] * 32'h10000) + (b[4*k+3] * 32'h1000000));
            sum = sum + words[k];
        end
        trl = b[4*l] + (b[4*l+1] * 32'h100) + (b[4*l+2] * 32'h10000) + (b[4*l+3] * 32'h1000000);

        got_q.delete();
        pulse_start(l);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("cpu_rst_after_start", {31'd0, cpu_rst_n}, 32'd0);
        check("flags_cleared", {30'd0, done, err}, 32'd0);
        check("ready_in_load", {31'd0, byte_ready}, 32'd1);

        if (intr_at >= 0) begin
            for (int i = 0; i < b.size(); i++) begin
                if (i < intr_at) part1.push_back(b[i]);
                else             part2.push_back(b[i]);
            end
            send(part1, gap_pct);
            pulse_start(7);
            check("busy_ignores_start", {31'd0, busy}, 32'd1);
            send(part2, gap_pct);
        end else begin
            send(b, gap_pct);
        end
        check("ready_drop", {31'd0, byte_ready}, 32'd0);

        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(done || err) && n < l + 20);
        check("verify_cycles", n, l + 1);
        check("done", {31'd0, done}, {31'd0, sum == trl});
        check("err", {31'd0, err}, {31'd0, sum != trl});
        check("busy_end", {31'd0, busy}, 32'd0);
        check("cpu_rst_end", {31'd0, cpu_rst_n}, 32'd1);

        check("write_count", got_q.size(), 4 * l);
        for (int i = 0; i < 4 * l && i < got_q.size(); i++) begin
            check("wr_we", {28'd0, got_q[i].we}, 32'd1 << (i % 4));
            check("wr_adr", got_q[i].adr, i / 4);
            check("wr_din", got_q[i].din, {4{b[i]}});
        end
        for (int k = 0; k < l; k++) check("ram_word", mem[k], words[k]);
    endtask

    task automatic rand_stream(input int l, input bit corrupt, output logic [7:0] b[$]);
        logic [31:0] sum = 0;
        logic [31:0] wd;
        b.delete();
        for (int k = 0; k < l; k++) begin
            wd = $urandom;
            sum = sum + wd;
            for (int i = 0; i < 4; i++) b.push_back(wd[8*i +: 8]);
        end
        if (corrupt) sum = sum ^ (32'd1 << $urandom_range(31, 0));
        for (int i = 0; i < 4; i++) b.push_back(sum[8*i +: 8]);
    endtask

    initial begin
        logic [7:0] b[$];
        logic [7:0] first5[$];

        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        rst_n = 1'b0; start = 1'b0; len = '0; byte_in = '0; byte_valid = 1'b0;
        #23;
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_we", {28'd0, ram_we}, 32'd0);
        check("rst_adr", ram_adr, 32'd0);
        check("rst_din", ram_din, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cpu", {31'd0, cpu_rst_n}, 32'd1);
        check("rst_flags", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // nominal
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h06, 8'h08, 8'h0A, 8'h0C};
        do_load(2, b, 0, -1);
        check("nominal_w0", mem[0], 32'h04030201);
        check("nominal_w1", mem[1], 32'h08070605);

        // checksum mismatch
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        do_load(2, b, 0, -1);

        // illegal lengths
        got_q.delete();
        busy_seen = 1'b0;
        pulse_start(0);
        check("len0_err", {30'd0, done, err}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        pulse_start(513);
        check("len513_err", {30'd0, done, err}, 32'd1);
        repeat (3) @(negedge clk);
        check("illegal_no_writes", got_q.size(), 32'd0);
        check("illegal_busy_seen", {31'd0, busy_seen}, 32'd0);

        // throttled
        rand_stream(3, 1'b0, b);
        do_load(3, b, 50, -1);

        // reset mid-load
        rand_stream(4, 1'b0, b);
        first5.delete();
        for (int i = 0; i < 5; i++) first5.push_back(b[i]);
        pulse_start(4);
        send(first5, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, byte_ready}, 32'd0);
        check("midrst_we", {28'd0, ram_we}, 32'd0);
        check("midrst_adr", ram_adr, 32'd0);
        check("midrst_din", ram_din, 32'd0);
        check("midrst_busy_cpu", {30'd0, busy, cpu_rst_n}, 32'd1);
        check("midrst_flags", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rand_stream(4, 1'b0, b);
        do_load(4, b, 0, -1);

        // start during busy
        rand_stream(2, 1'b0, b);
        do_load(2, b, 0, 3);

        // random loads
        for (int r = 0; r < 8; r++) begin
            int l;
            l = $urandom_range(6, 1);
            rand_stream(l, ($urandom_range(2, 0) == 0), b);
            do_load(l, b, $urandom_range(60, 0), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
